// File: rtl/line_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : line_mem_arbiter_if                                             |
// | Purpose  : Request/response bundle between NCH line requesters and the     |
// |            shared line store. Channel i occupies bit i of req/req_we/      |
// |            resp_valid, req_addr[i*ADDR_W +: ADDR_W] and                    |
// |            req_wline[i*LINE_W +: LINE_W].                                  |
// | Modports : master - requester side (drives req*, reads resp*/busy/grant)   |
// |            slave  - arbiter side (reads req*, drives resp*/busy/grant)     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface line_mem_arbiter_if #(
    parameter int NCH    = 3,
    parameter int LINE_W = 128,
    parameter int ADDR_W = 10,
    parameter int GID_W  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic [NCH-1:0]        req;
    logic [NCH-1:0]        req_we;
    logic [NCH*ADDR_W-1:0] req_addr;
    logic [NCH*LINE_W-1:0] req_wline;
    logic [NCH-1:0]        resp_valid;
    logic [LINE_W-1:0]     resp_line;
    logic                  busy;
    logic [GID_W-1:0]      grant_id;

    modport master (
        output req, req_we, req_addr, req_wline,
        input  resp_valid, resp_line, busy, grant_id
    );

    modport slave (
        input  req, req_we, req_addr, req_wline,
        output resp_valid, resp_line, busy, grant_id
    );
endinterface
`default_nettype wire

// File: rtl/line_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : line_mem_arbiter                                                |
// | Purpose  : Shared line store (2**ADDR_W lines of LINE_W bits) serving NCH  |
// |            requesters one access at a time through a round-robin arbiter. |
// |            A granted access completes LATENCY cycles after its grant with  |
// |            a one-cycle resp_valid pulse on the owning channel.             |
// | Ports    : clk, rst (sync, active high)                                    |
// |            bus (slave)  req/req_we/req_addr/req_wline in,                  |
// |                         resp_valid/resp_line/busy/grant_id out             |
// |            stat_grants, stat_wait (only with LINE_MEM_STATS_EN defined)    |
// | Options  : LINE_MEM_STATS_EN - adds per-channel completion counters and a  |
// |            cycles-with-unserved-request counter                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module line_mem_arbiter #(
    parameter int NCH     = 3,
    parameter int LINE_W  = 128,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    line_mem_arbiter_if.slave bus
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [NCH*32-1:0] stat_grants,
    output logic [31:0]       stat_wait
`endif
);
    localparam int c_gid_w = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int c_cnt_w = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);
    localparam bit c_lat1 = (LATENCY == 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_gid_w-1:0]  r_id;
    logic [c_gid_w-1:0]  r_rr_ptr;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]   r_wline;
    logic [LINE_W-1:0]   r_resp_line;
    logic [LINE_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

    logic [c_gid_w-1:0]  w_win_id;
    logic [c_gid_w-1:0]  w_ptr_nxt;
    logic                w_any_req;
    logic                w_win_we;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [LINE_W-1:0]   w_win_wline;
    logic                w_grant;
    logic                w_done;
    logic                w_rd_load;
    logic [ADDR_W-1:0]   w_rd_addr;

    // Round-robin pick: scan from the highest offset down so the channel
    // closest to r_rr_ptr is the one left in w_win_id.
    always_comb begin
        int                 idx;
        logic [c_gid_w-1:0] w_idx;
        idx       = 0;
        w_idx     = '0;
        w_win_id  = '0;
        w_any_req = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            w_idx = c_gid_w'(idx);
            if (bus.req[w_idx]) begin
                w_win_id  = w_idx;
                w_any_req = 1'b1;
            end
        end
    end

    assign w_win_we    = bus.req_we[w_win_id];
    assign w_win_addr  = bus.req_addr[int'(w_win_id)*ADDR_W +: ADDR_W];
    assign w_win_wline = bus.req_wline[int'(w_win_id)*LINE_W +: LINE_W];

    assign w_grant   = (r_state == ST_IDLE) && w_any_req;
    assign w_done    = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_ptr_nxt = (r_id == c_gid_w'(NCH - 1)) ? '0 : r_id + 1'b1;

    // Read data is captured on the edge that enters the completion cycle so
    // it is presented together with resp_valid. With LATENCY==1 that edge is
    // the grant edge itself, hence the address comes straight from the winner.
    assign w_rd_load = c_lat1 ? (w_grant && !w_win_we)
                              : ((r_state == ST_BUSY) && (r_cnt == c_cnt_w'(1)) && !r_we);
    assign w_rd_addr = c_lat1 ? w_win_addr : r_addr;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req)     w_state_nxt = ST_BUSY;
            ST_BUSY: if (r_cnt == '0)   w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_id        <= '0;
            r_rr_ptr    <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wline     <= '0;
            r_resp_line <= '0;
        end else begin
            if (w_grant) begin
                r_cnt   <= c_cnt_load;
                r_id    <= w_win_id;
                r_we    <= w_win_we;
                r_addr  <= w_win_addr;
                r_wline <= w_win_wline;
            end else if ((r_state == ST_BUSY) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_done)    r_rr_ptr    <= w_ptr_nxt;
            if (w_rd_load) r_resp_line <= r_mem[w_rd_addr];
        end
    end

    // Storage is not reset; a reset coinciding with completion drops the write.
    always_ff @(posedge clk) begin
        if (!rst && w_done && r_we) r_mem[r_addr] <= r_wline;
    end

    always_comb begin
        bus.resp_valid = '0;
        if (w_done) bus.resp_valid[r_id] = 1'b1;
    end

    assign bus.resp_line = r_resp_line;
    assign bus.busy      = (r_state == ST_BUSY);
    assign bus.grant_id  = r_id;

`ifdef LINE_MEM_STATS_EN
    logic [NCH-1:0] w_served;
    logic [31:0]    r_stat_wait;

    // The channel being granted in IDLE already counts as served that cycle.
    always_comb begin
        w_served = '0;
        if (w_grant)                    w_served[w_win_id] = 1'b1;
        else if (r_state == ST_BUSY)    w_served[r_id]     = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)                            r_stat_wait <= '0;
        else if (|(bus.req & ~w_served))    r_stat_wait <= r_stat_wait + 32'd1;
    end
    assign stat_wait = r_stat_wait;

    for (genvar g = 0; g < NCH; g++) begin : g_stat
        logic [31:0] r_grants;
        always_ff @(posedge clk) begin
            if (rst)                                    r_grants <= '0;
            else if (w_done && (r_id == c_gid_w'(g)))   r_grants <= r_grants + 32'd1;
        end
        assign stat_grants[g*32 +: 32] = r_grants;
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_line_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_line_mem_arbiter                                             |
// | Purpose  : Self-checking bench for line_mem_arbiter. A transaction-level   |
// |            model (pending table, grant timestamps, line map) predicts      |
// |            every cycle of the NCH=3/LATENCY=3 instance; a second instance  |
// |            with LATENCY=1 covers the same-address read/write race.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_line_mem_arbiter;
    localparam int NCH   = 3;
    localparam int LW    = 128;
    localparam int AW    = 10;
    localparam int LAT   = 3;
    localparam int NCH_B = 2;
    localparam int LW_B  = 32;
    localparam int AW_B  = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_mem_arbiter_if #(.NCH(NCH),   .LINE_W(LW),   .ADDR_W(AW))   bus   ();
    line_mem_arbiter_if #(.NCH(NCH_B), .LINE_W(LW_B), .ADDR_W(AW_B)) bus_b ();

`ifdef LINE_MEM_STATS_EN
    logic [NCH*32-1:0]   stat_grants;
    logic [31:0]         stat_wait;
    logic [NCH_B*32-1:0] stat_grants_b;
    logic [31:0]         stat_wait_b;
`endif

    line_mem_arbiter #(.NCH(NCH), .LINE_W(LW), .ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
`ifdef LINE_MEM_STATS_EN
        , .stat_grants(stat_grants), .stat_wait(stat_wait)
`endif
    );

    line_mem_arbiter #(.NCH(NCH_B), .LINE_W(LW_B), .ADDR_W(AW_B), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
`ifdef LINE_MEM_STATS_EN
        , .stat_grants(stat_grants_b), .stat_wait(stat_wait_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Requester-side state: 0 idle, 1 waiting, 2 completing (still holding).
    int               pend   [NCH];
    logic             p_we   [NCH];
    logic [AW-1:0]    p_addr [NCH];
    logic [LW-1:0]    p_wl   [NCH];

    // Reference: line map plus the one access in flight and its due cycle.
    logic [LW-1:0]    mm [int];
    bit               m_busy;
    int               m_id, m_done, m_ptr, cyc;
    logic [LW-1:0]    m_line;
    int               done_ch[$];
    int               done_t[$];

    localparam logic [LW-1:0] A5 = {16{8'hA5}};
    localparam logic [LW-1:0] L11 = {16{8'h11}};
    localparam logic [LW-1:0] L22 = {16{8'h22}};

    task automatic drive();
        logic [NCH-1:0] rq, we;
        rq = '0;
        we = '0;
        for (int i = 0; i < NCH; i++) begin
            if (pend[i] != 0) rq = rq | (NCH'(1) << i);
            if (p_we[i])      we = we | (NCH'(1) << i);
            bus.req_addr[i*AW +: AW]  = p_addr[i];
            bus.req_wline[i*LW +: LW] = p_wl[i];
        end
        bus.req    = rq;
        bus.req_we = we;
    endtask

    task automatic issue(input int ch, input logic we, input logic [AW-1:0] a, input logic [LW-1:0] wl);
        pend[ch]   = 1;
        p_we[ch]   = we;
        p_addr[ch] = a;
        p_wl[ch]   = wl;
        drive();
    endtask

    // Ends the current cycle: decide what the arbiter does with this cycle's
    // inputs, cross the edge, then compare the new cycle against the model.
    task automatic tick();
        logic [NCH-1:0] exp_rv;
        if (rst) begin
            m_busy = 1'b0;
            m_ptr  = 0;
            m_line = '0;
        end else if (m_busy && cyc == m_done) begin
            if (p_we[m_id]) mm[int'(p_addr[m_id])] = p_wl[m_id];
            m_ptr  = (m_id + 1) % NCH;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            for (int k = 0; k < NCH; k++) begin
                int c = (m_ptr + k) % NCH;
                if (pend[c] == 1) begin
                    m_busy = 1'b1;
                    m_id   = c;
                    m_done = cyc + LAT;
                    break;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NCH; i++) if (pend[i] == 2) pend[i] = 0;
        drive();
        exp_rv = '0;
        if (m_busy && cyc == m_done) begin
            exp_rv = NCH'(1) << m_id;
            if (!p_we[m_id]) m_line = mm[int'(p_addr[m_id])];
            pend[m_id] = 2;
            done_ch.push_back(m_id);
            done_t.push_back(cyc);
        end
        check("resp_valid", LW'(bus.resp_valid), LW'(exp_rv));
        check("busy", LW'(bus.busy), LW'(m_busy));
        if (m_busy) check("grant_id", LW'(bus.grant_id), LW'(m_id));
        check("resp_line", bus.resp_line, m_line);
    endtask

    task automatic wait_done(input int ch, input int budget);
        int n = 0;
        while ((((bus.resp_valid >> ch) & NCH'(1)) == '0) && n < budget) begin
            tick();
            n++;
        end
        check("wait_done", LW'((bus.resp_valid >> ch) & NCH'(1)), LW'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) pend[i] = 0;
        drive();
        bus_b.req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, s;
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            pend[i] = 0; p_we[i] = 1'b0; p_addr[i] = '0; p_wl[i] = '0;
        end
        drive();
        bus_b.req = '0; bus_b.req_we = '0; bus_b.req_addr = '0; bus_b.req_wline = '0;
        m_busy = 1'b0; m_id = 0; m_done = 0; m_ptr = 0; cyc = 0; m_line = '0;

        // Reset state
        do_reset();
        check("rst_busy", LW'(bus.busy), LW'(0));
        check("rst_rv", LW'(bus.resp_valid), LW'(0));
        check("rst_line", bus.resp_line, '0);
        check("rst_rv_b", LW'(bus_b.resp_valid), LW'(0));

        // 1: ch2 write then ch0 read of the same line
        issue(2, 1'b1, AW'(5), A5);
        t = cyc;
        repeat (3) tick();
        check("t1_wr_resp", LW'(bus.resp_valid), LW'(3'b100));
        issue(0, 1'b0, AW'(5), '0);
        s = cyc;
        repeat (4) tick();
        check("t1_rd_cycle", LW'(cyc - s), LW'(4));
        check("t1_rd_resp", LW'(bus.resp_valid), LW'(3'b001));
        check("t1_rd_line", bus.resp_line, A5);

        // 2: simultaneous ch0/ch1 after reset
        do_reset();
        issue(0, 1'b0, AW'(5), '0);
        issue(1, 1'b0, AW'(5), '0);
        t = cyc;
        repeat (3) tick();
        check("t2_ch0_resp", LW'(bus.resp_valid), LW'(3'b001));
        repeat (2) tick();
        check("t2_gid", LW'(bus.grant_id), LW'(1));
        repeat (2) tick();
        check("t2_ch1_cycle", LW'(cyc - t), LW'(7));
        check("t2_ch1_resp", LW'(bus.resp_valid), LW'(3'b010));
        check("t2_ch1_line", bus.resp_line, A5);
        tick();
`ifdef LINE_MEM_STATS_EN
        check("t6_grants", LW'(stat_grants), LW'({32'd0, 32'd1, 32'd1}));
        check("t6_wait", LW'(stat_wait), LW'(4));
`endif

        // 3: continuous reads on all channels
        do_reset();
        done_ch.delete();
        done_t.delete();
        for (int i = 0; i < NCH; i++) issue(i, 1'b0, AW'(5), '0);
        repeat (24) begin
            tick();
            for (int i = 0; i < NCH; i++) if (pend[i] == 0) issue(i, 1'b0, AW'(5), '0);
        end
        check("t3_count", LW'(done_ch.size() >= 6), LW'(1));
        for (int k = 0; k < 6 && k < done_ch.size(); k++) begin
            check("t3_order", LW'(done_ch[k]), LW'(k % 3));
            if (k > 0) check("t3_gap", LW'(done_t[k] - done_t[k-1]), LW'(4));
        end

        // 4: reset in the middle of a write
        do_reset();
        issue(1, 1'b1, AW'(9), L11);
        wait_done(1, 10);
        tick();
        issue(1, 1'b1, AW'(9), L22);
        tick();
        rst = 1'b1;
        for (int i = 0; i < NCH; i++) pend[i] = 0;
        drive();
        tick();
        check("t4_busy", LW'(bus.busy), LW'(0));
        check("t4_rv", LW'(bus.resp_valid), LW'(0));
        rst = 1'b0;
        repeat (3) begin
            tick();
            check("t4_no_rv", LW'(bus.resp_valid), LW'(0));
        end
        issue(0, 1'b0, AW'(9), '0);
        wait_done(0, 10);
        check("t4_old_line", bus.resp_line, L11);
        tick();

        // 5: LATENCY=1, read and write to one line in the same cycle
        bus_b.req = 2'b10; bus_b.req_we = 2'b10;
        bus_b.req_addr = {AW_B'(3), AW_B'(3)};
        bus_b.req_wline = {32'h0BAD_0001, 32'h0};
        tick();
        check("t5_pre_rv", LW'(bus_b.resp_valid), LW'(2'b10));
        tick();
        bus_b.req = 2'b11;
        bus_b.req_wline = {32'h600D_0002, 32'h0};
        tick();
        check("t5_rd_rv", LW'(bus_b.resp_valid), LW'(2'b01));
        check("t5_rd_old", LW'(bus_b.resp_line), LW'(32'h0BAD_0001));
        tick();
        bus_b.req = 2'b10;
        check("t5_idle", LW'(bus_b.busy), LW'(0));
        tick();
        check("t5_wr_rv", LW'(bus_b.resp_valid), LW'(2'b10));
        check("t5_wr_line", LW'(bus_b.resp_line), LW'(32'h0BAD_0001));
        tick();
        bus_b.req = 2'b01; bus_b.req_we = 2'b00;
        tick();
        check("t5_rerd_rv", LW'(bus_b.resp_valid), LW'(2'b01));
        check("t5_rerd_new", LW'(bus_b.resp_line), LW'(32'h600D_0002));
        tick();
        bus_b.req = '0;

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NCH; i++) begin
                if (pend[i] == 0 && $urandom_range(0, 99) < 40) begin
                    int a;
                    a = int'($urandom_range(0, 7));
                    issue(i, (!mm.exists(a)) || ($urandom_range(0, 1) == 1), AW'(a),
                          {$urandom, $urandom, $urandom, $urandom});
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
